// File: rtl/tile_pkg.sv
// Shared constants and types for the scrolling tile renderer.
package tile_pkg;

    localparam int unsigned TILE_W   = 160;
    localparam int unsigned TILE_H   = 120;
    localparam int unsigned ROWS     = 5;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam logic [11:0] COL_TILE = 12'h000;
    localparam logic [11:0] COL_BG   = 12'hFFF;
    localparam logic [11:0] COL_GRID = 12'h888;

    typedef struct packed {
        logic       valid;
        logic [1:0] lane;
    } row_t;

    function automatic logic on_row_edge(input logic [9:0] ey);
        return ey == 10'd0
            || ey == 10'(TILE_H)
            || ey == 10'(2 * TILE_H)
            || ey == 10'(3 * TILE_H)
            || ey == 10'(4 * TILE_H);
    endfunction

    function automatic logic on_lane_edge(input logic [9:0] x);
        return x == 10'd0
            || x == 10'(TILE_W)
            || x == 10'(2 * TILE_W)
            || x == 10'(3 * TILE_W)
            || x == 10'(H_ACTIVE - 1);
    endfunction

endpackage

// File: rtl/tile_row_buffer.sv
// Row ring, scroll offset and once-per-frame advance.
module tile_row_buffer
    import tile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                v_sync_in,
    input  logic                pause,
    input  logic [3:0]          speed,
    input  logic                new_row_valid,
    input  logic [1:0]          new_row_lane,
    output logic                row_shift,
    output logic [6:0]          scroll_offset,
    output row_t [ROWS-1:0]     rows
);

    logic       v_sync_q;
    logic       frame_tick;
    logic       advance;
    logic       wrap;
    logic [7:0] sum;
    row_t       new_entry;

    assign frame_tick = v_sync_q & ~v_sync_in;
    assign sum        = {1'b0, scroll_offset} + {4'b0, speed};
    assign advance    = frame_tick & ~pause & (speed != 4'd0);
    assign wrap       = sum >= 8'(TILE_H);

    // Combinational so the game logic sees it in the cycle its row is taken.
    assign row_shift  = advance & wrap & ~reset;

    assign new_entry.valid = new_row_valid;
    assign new_entry.lane  = new_row_lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_sync_q      <= 1'b1;
            scroll_offset <= '0;
            rows          <= '0;
        end else begin
            v_sync_q <= v_sync_in;
            if (advance) begin
                if (wrap) begin
                    scroll_offset <= 7'(sum - 8'(TILE_H));
                    rows          <= {rows[ROWS-2:0], new_entry};
                end else begin
                    scroll_offset <= sum[6:0];
                end
            end
        end
    end

endmodule

// File: rtl/tile_scroll_renderer.sv
// Two-stage pixel pipeline drawing a scrolling 4-lane tile field.
module tile_scroll_renderer
    import tile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        inside_video_in,
    input  logic [9:0]  x_position,
    input  logic [8:0]  y_position,
    input  logic        pause,
    input  logic [3:0]  speed,
    input  logic        new_row_valid,
    input  logic [1:0]  new_row_lane,
    output logic        row_shift,
    output logic        bottom_row_valid,
    output logic [1:0]  bottom_row_lane,
    output logic [6:0]  scroll_offset,
    output logic [11:0] rgb,
    output logic        h_sync,
    output logic        v_sync
);

    row_t [ROWS-1:0] rows;

    tile_row_buffer u_row_buffer (
        .clk           (clk),
        .reset         (reset),
        .v_sync_in     (v_sync_in),
        .pause         (pause),
        .speed         (speed),
        .new_row_valid (new_row_valid),
        .new_row_lane  (new_row_lane),
        .row_shift     (row_shift),
        .scroll_offset (scroll_offset),
        .rows          (rows)
    );

    assign bottom_row_valid = rows[ROWS-1].valid;
    assign bottom_row_lane  = rows[ROWS-1].lane;

    logic [9:0] ey;
    logic [2:0] row_d;
    logic [1:0] lane_d;
    logic       grid_d;

    // ey is the pixel's y within the buffer, with row 0 starting above screen.
    assign ey = 10'(y_position) + 10'(TILE_H) - 10'(scroll_offset);

    assign row_d = 3'(ey >= 10'(TILE_H))
                 + 3'(ey >= 10'(2 * TILE_H))
                 + 3'(ey >= 10'(3 * TILE_H))
                 + 3'(ey >= 10'(4 * TILE_H));

    assign lane_d = 2'(x_position >= 10'(TILE_W))
                  + 2'(x_position >= 10'(2 * TILE_W))
                  + 2'(x_position >= 10'(3 * TILE_W));

    assign grid_d = on_lane_edge(x_position) | on_row_edge(ey);

    logic [2:0] s1_row;
    logic [1:0] s1_lane;
    logic       s1_grid;
    logic       s1_act;
    logic       s1_hs;
    logic       s1_vs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_row  <= '0;
            s1_lane <= '0;
            s1_grid <= 1'b0;
            s1_act  <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
        end else begin
            s1_row  <= row_d;
            s1_lane <= lane_d;
            s1_grid <= grid_d;
            s1_act  <= inside_video_in;
            s1_hs   <= h_sync_in;
            s1_vs   <= v_sync_in;
        end
    end

    row_t        sel;
    logic [11:0] pix_d;

    always_comb begin
        sel = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (s1_row == 3'(i)) begin
                sel = rows[i];
            end
        end
    end

    always_comb begin
        pix_d = COL_BG;
        if (!s1_act) begin
            pix_d = 12'h000;
        end else if (s1_grid) begin
            pix_d = COL_GRID;
        end else if (sel.valid && sel.lane == s1_lane) begin
            pix_d = COL_TILE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb    <= '0;
            h_sync <= 1'b1;
            v_sync <= 1'b1;
        end else begin
            rgb    <= pix_d;
            h_sync <= s1_hs;
            v_sync <= s1_vs;
        end
    end

endmodule

// File: tb/tb_tile_scroll_renderer.sv
// Directed bench for tile_scroll_renderer.
module tb_tile_scroll_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        inside_video_in;
    logic [9:0]  x_position;
    logic [8:0]  y_position;
    logic        pause;
    logic [3:0]  speed;
    logic        new_row_valid;
    logic [1:0]  new_row_lane;
    logic        row_shift;
    logic        bottom_row_valid;
    logic [1:0]  bottom_row_lane;
    logic [6:0]  scroll_offset;
    logic [11:0] rgb;
    logic        h_sync;
    logic        v_sync;

    int errors = 0;
    int checks = 0;
    int exp_off = 0;
    int p;
    int total;

    always #5 clk = ~clk;

    tile_scroll_renderer dut (
        .clk              (clk),
        .reset            (reset),
        .h_sync_in        (h_sync_in),
        .v_sync_in        (v_sync_in),
        .inside_video_in  (inside_video_in),
        .x_position       (x_position),
        .y_position       (y_position),
        .pause            (pause),
        .speed            (speed),
        .new_row_valid    (new_row_valid),
        .new_row_lane     (new_row_lane),
        .row_shift        (row_shift),
        .bottom_row_valid (bottom_row_valid),
        .bottom_row_lane  (bottom_row_lane),
        .scroll_offset    (scroll_offset),
        .rgb              (rgb),
        .h_sync           (h_sync),
        .v_sync           (v_sync)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame tick; counts row_shift pulses seen mid-cycle.
    task automatic frame(output int pulses);
        pulses = 0;
        @(posedge clk);
        #1 v_sync_in = 1'b0;
        #3 if (row_shift === 1'b1) pulses++;
        @(posedge clk);
        #1 v_sync_in = 1'b1;
        #3 if (row_shift === 1'b1) pulses++;
        @(posedge clk);
        #1;
        if (!pause && speed != 4'd0) begin
            exp_off += int'(speed);
            if (exp_off >= 120) exp_off -= 120;
        end
    endtask

    // Run frames until a shift happens, bounded to 20 frames.
    task automatic shift_until(output int pulses);
        int fp;
        pulses = 0;
        for (int f = 0; f < 20; f++) begin
            frame(fp);
            pulses += fp;
            if (fp != 0) break;
        end
    endtask

    task automatic pix(input string tag, input logic [9:0] x,
                       input logic [8:0] y, input logic act,
                       input logic [11:0] exp);
        @(posedge clk);
        #1;
        x_position      = x;
        y_position      = y;
        inside_video_in = act;
        h_sync_in       = 1'b0;
        @(posedge clk);
        #1;
        x_position      = 10'd0;
        y_position      = 9'd0;
        inside_video_in = 1'b0;
        h_sync_in       = 1'b1;
        @(posedge clk);
        #1;
        chk(tag, 32'(rgb), 32'(exp));
        chk({tag, "_hs"}, 32'(h_sync), 32'd0);
        chk({tag, "_vs"}, 32'(v_sync), 32'd1);
    endtask

    initial begin
        reset           = 1'b1;
        h_sync_in       = 1'b1;
        v_sync_in       = 1'b1;
        inside_video_in = 1'b0;
        x_position      = '0;
        y_position      = '0;
        pause           = 1'b0;
        speed           = 4'd0;
        new_row_valid   = 1'b0;
        new_row_lane    = 2'd0;

        #2;
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_hs", 32'(h_sync), 32'd1);
        chk("rst_vs", 32'(v_sync), 32'd1);
        chk("rst_off", 32'(scroll_offset), 32'd0);
        chk("rst_bot", 32'(bottom_row_valid), 32'd0);
        chk("rst_shift", 32'(row_shift), 32'd0);

        @(posedge clk);
        #1 reset = 1'b0;
        speed = 4'd7;
        frame(p);
        chk("pre_off", 32'(scroll_offset), 32'd7);

        // mid-line asynchronous reset
        @(posedge clk);
        #1;
        inside_video_in = 1'b1;
        x_position      = 10'd100;
        y_position      = 9'd100;
        h_sync_in       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rgb", 32'(rgb), 32'hFFF);
        chk("pre_hs", 32'(h_sync), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rgb", 32'(rgb), 32'h0);
        chk("mid_hs", 32'(h_sync), 32'd1);
        chk("mid_vs", 32'(v_sync), 32'd1);
        chk("mid_off", 32'(scroll_offset), 32'd0);
        chk("mid_bot", 32'(bottom_row_valid), 32'd0);
        @(posedge clk);
        #1;
        reset           = 1'b0;
        inside_video_in = 1'b0;
        h_sync_in       = 1'b1;
        exp_off         = 0;

        pix("bg_10_10", 10'd10, 9'd10, 1'b1, 12'hFFF);

        // 17 frames at speed 7 reach 119 without a shift
        speed = 4'd7;
        new_row_valid = 1'b1;
        new_row_lane  = 2'd1;
        total = 0;
        for (int f = 0; f < 17; f++) begin
            frame(p);
            total += p;
        end
        chk("off_119", 32'(scroll_offset), 32'd119);
        chk("no_shift17", 32'(total), 32'd0);
        frame(p);
        chk("shift18", 32'(p), 32'd1);
        chk("off_6", 32'(scroll_offset), 32'd6);

        // shift chain: lanes 1 (done), 2, 3, 0, 1
        speed = 4'd15;
        new_row_lane = 2'd2;
        shift_until(p);
        chk("sh2", 32'(p), 32'd1);
        new_row_lane = 2'd3;
        shift_until(p);
        chk("sh3", 32'(p), 32'd1);
        new_row_lane = 2'd0;
        shift_until(p);
        chk("sh4", 32'(p), 32'd1);
        chk("bot4_v", 32'(bottom_row_valid), 32'd0);
        new_row_lane = 2'd1;
        shift_until(p);
        chk("sh5", 32'(p), 32'd1);
        chk("bot5_v", 32'(bottom_row_valid), 32'd1);
        chk("bot5_l", 32'(bottom_row_lane), 32'd1);
        new_row_valid = 1'b0;
        new_row_lane  = 2'd3;
        shift_until(p);
        chk("sh6", 32'(p), 32'd1);
        chk("bot6_v", 32'(bottom_row_valid), 32'd1);
        chk("bot6_l", 32'(bottom_row_lane), 32'd2);
        chk("off_model", 32'(scroll_offset), 32'(exp_off));

        // rebuild: offset 0, row[2] = {1, lane 2}
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_off = 0;
        speed = 4'd15;
        new_row_valid = 1'b1;
        new_row_lane  = 2'd2;
        shift_until(p);
        new_row_valid = 1'b0;
        new_row_lane  = 2'd0;
        shift_until(p);
        shift_until(p);
        chk("r_off0", 32'(scroll_offset), 32'd0);

        pix("tile_400", 10'd400, 9'd150, 1'b1, 12'h000);
        pix("bg_100", 10'd100, 9'd150, 1'b1, 12'hFFF);
        pix("grid_x320", 10'd320, 9'd150, 1'b1, 12'h888);
        pix("grid_x320b", 10'd320, 9'd37, 1'b1, 12'h888);
        pix("grid_x639", 10'd639, 9'd150, 1'b1, 12'h888);
        pix("grid_y0", 10'd50, 9'd0, 1'b1, 12'h888);
        pix("bg_row1", 10'd400, 9'd30, 1'b1, 12'hFFF);
        pix("bg_row3", 10'd400, 9'd300, 1'b1, 12'hFFF);
        pix("lane3_edge", 10'd481, 9'd150, 1'b1, 12'hFFF);

        // pause and zero speed freeze scrolling
        pause = 1'b1;
        speed = 4'd15;
        frame(p);
        chk("pause_sh", 32'(p), 32'd0);
        chk("pause_off", 32'(scroll_offset), 32'd0);
        pause = 1'b0;
        speed = 4'd0;
        frame(p);
        chk("zero_sh", 32'(p), 32'd0);
        chk("zero_off", 32'(scroll_offset), 32'd0);
        speed = 4'd15;
        frame(p);
        chk("resume_off", 32'(scroll_offset), 32'd15);

        pix("blank", 10'd100, 9'd150, 1'b0, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tile_scroll_renderer.md
Name: tile_scroll_renderer

Overview:
- Pixel-stage consumer of the VGA timing generator: takes h_sync/v_sync/inside_video and x/y position at 25 MHz, and produces 12-bit RGB plus delayed syncs for the VGA pins.
- Holds a 5-row ring of tile rows (4 lanes × 120 px high) and scrolls it downward by `speed` pixels once per frame.
- Requests a new row from the game logic each time a full tile height has scrolled.

Parameters:
- TILE_W, 160, lane width in pixels (4 lanes across 640)
- TILE_H, 120, tile height in pixels (4 visible rows plus 1 partial)
- ROWS, 5, row buffer depth; index 0 is top, ROWS-1 is bottom
- COL_TILE, 12'h000, colour of a black (active) tile
- COL_BG, 12'hFFF, colour of an empty cell
- COL_GRID, 12'h888, colour of grid lines

Ports:
- clk  in  1  25 MHz pixel clock
- reset  in  1  asynchronous, active-high
- h_sync_in  in  1  from timing generator
- v_sync_in  in  1  from timing generator; low during lines 0–1
- inside_video_in  in  1  active-area flag
- x_position  in  10  pixel x; 0..639 when active
- y_position  in  9  pixel y; 0..479 when active
- pause  in  1  freeze scrolling
- speed  in  4  pixels per frame; must be less than TILE_H
- new_row_valid  in  1  new row contains a tile
- new_row_lane  in  2  lane of the new tile
- row_shift  out  1  one-cycle pulse when the buffer shifts and the new row is consumed
- bottom_row_valid  out  1  entry ROWS-1 valid bit
- bottom_row_lane  out  2  entry ROWS-1 lane
- scroll_offset  out  7  current offset, 0..TILE_H-1
- rgb  out  12  4:4:4 colour
- h_sync  out  1  h_sync_in delayed 2 cycles
- v_sync  out  1  v_sync_in delayed 2 cycles

Behaviour:
- **Reset:**
  - scroll_offset = 0; all row entries = {valid 0, lane 0}.
  - row_shift = 0; rgb = 0; h_sync = 1, v_sync = 1; both sync delay stages = 1.
  - Internal registered copy of v_sync_in = 1.
  - Reset mid-frame takes effect immediately (async); normal operation resumes on the next clk.
- **Frame tick:** asserted for one cycle when the registered v_sync_in = 1 and the current v_sync_in = 0. This falls in vertical blanking, so no visible tearing.
- **Scroll update** (on frame tick only):
  - pause = 1 or speed = 0: no change.
  - Otherwise sum = scroll_offset + speed (8-bit).
  - If sum < TILE_H: scroll_offset <= sum.
  - If sum >= TILE_H: scroll_offset <= sum − TILE_H; row[k] <= row[k−1] for k = ROWS−1..1; row[0] <= {new_row_valid, new_row_lane}; row_shift = 1 for that cycle.
  - Old row[ROWS−1] is discarded.
  - At most one shift per frame, guaranteed by speed < TILE_H.
- **Bottom row outputs:** bottom_row_valid and bottom_row_lane reflect row[ROWS−1] combinationally from its register, and update in the cycle after the shift.
- **Pixel pipeline** (latency 2 cycles; h_sync, v_sync and active flag delayed identically):
  - Stage 1 registers:
    - ey = y_position + TILE_H − scroll_offset (10-bit; range 1..599).
    - row index = number of thresholds {120, 240, 360, 480} that ey is ≥, giving 0..4.
    - lane = number of thresholds {160, 320, 480} that x_position is ≥, giving 0..3.
    - grid flag = 1 if x_position is one of 0, 160, 320, 480, 639, or ey is a multiple of TILE_H (compare against the 5 constants).
    - Active flag.
  - Stage 2 (rgb register):
    - active = 0 → rgb = 0.
    - Else grid → COL_GRID.
    - Else row[idx].valid and row[idx].lane == lane → COL_TILE.
    - Else COL_BG.
- **Buffer vs. pixels:** row buffer changes only on frame tick, so stage 2 never sees a mid-frame change.
- **Out-of-range coordinates:** when inside_video_in = 0, the stage-1 result is don't-care and the output must be 0.

Decomposition:
- Shared package `tile_pkg`:
  - TILE_W, TILE_H, ROWS, colour constants.
  - Row entry typedef {valid, lane[1:0]}.
  - H/V active sizes 640/480.
- One sub-module, `tile_row_buffer`: scroll offset register, frame-tick edge detect, shift logic, row_shift.
- The top level holds the 2-stage pixel pipeline.

Test Plan:
- **Reset:** assert reset mid-line → rgb = 0, h_sync = v_sync = 1, scroll_offset = 0, bottom_row_valid = 0; after release, an active pixel (x = 10, y = 10) gives COL_BG 2 cycles later.
- **Scroll:** speed = 7, pause = 0, 17 frames → offset = 119, no row_shift; frame 18 → offset = 6 and exactly one row_shift pulse, coincident with the frame tick.
- **Shift chain:** present new_row lanes 1, 2, 3, 0, 1 (valid = 1) over 5 shifts → bottom_row_lane = 1 after the 5th shift; the 6th shift with new_row_valid = 0 leaves bottom = lane 2.
- **Rendering:** offset = 0, row[2] = {1, lane 2} → pixel (x = 400, y = 150) is COL_TILE; (x = 100, y = 150) is COL_BG; (x = 320, any y) is COL_GRID; each appears 2 cycles after input, with syncs aligned.
- **Pause:** pause = 1 across a frame tick with speed = 15 → offset unchanged, no row_shift; speed = 0 behaves the same.
- **Blanking:** inside_video_in = 0 with x/y in range → rgb = 0.
